// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory slave at the responding end of the CPU load/store interface.
// It accepts one word-aligned load or store at a time, waits WAIT cycles and
// then returns a single-cycle response carrying load data and a fault flag.
// The word array holds 2**ADDR_W 32-bit words. Any address that is
// misaligned or beyond the array's byte span faults. A faulting address is
// never aliased onto a legal word.
//
// Parameters:
//   ADDR_W      word-index width (array depth 2**ADDR_W)
//   WAIT        wait-state cycles between acceptance and response (0..15)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low (0 = in reset)
//   req_valid   request present
//   req_ready   responder idle and able to accept (Moore, from state only)
//   req_wen     1 = store, 0 = load (sampled at acceptance)
//   req_addr    byte address (sampled at acceptance)
//   req_wdata   store data (sampled at acceptance)
//   resp_valid  one-cycle response pulse
//   resp_rdata  load data, zero outside the response cycle
//   resp_err    access fault, zero outside the response cycle
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    // The counter is loaded with WAIT-1. When WAIT is 0 the WAIT state is
    // skipped entirely, so the load value is unused and simply set to 0.
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t             state;
    state_t             state_next;
    logic [3:0]         wait_cnt;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;
    logic [31:0]        mem [2**ADDR_W];

    logic               accept;
    logic               addr_legal;
    logic [ADDR_W-1:0]  word_idx;

    assign accept     = (state == S_IDLE) && req_valid;
    // The shift keeps the upper-bit test valid for any ADDR_W. A part-select
    // of req_addr[31:ADDR_W+2] would be empty for large ADDR_W.
    assign addr_legal = (req_addr[1:0] == 2'b00) &&
                        ((req_addr >> (ADDR_W + 2)) == 32'd0);
    assign word_idx   = req_addr[ADDR_W+1:2];

    // State, wait counter and response register. The response is captured
    // on the acceptance edge, so later changes to req_* cannot affect it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                wait_cnt    <= WAIT_LOAD;
                rsp_err_q   <= !addr_legal;
                rsp_rdata_q <= (addr_legal && !req_wen) ? mem[word_idx] : 32'd0;
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // The word array is deliberately outside the reset domain. Reset leaves
    // its contents intact, so a store committed before reset survives.
    always_ff @(posedge clk) begin
        if (accept && req_wen && addr_legal) begin
            mem[word_idx] <= req_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = (WAIT == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state alone. Response data is gated to
    // zero outside RESP.
    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
        resp_rdata = (state == S_RESP) ? rsp_rdata_q : 32'd0;
        resp_err   = (state == S_RESP) ? rsp_err_q   : 1'b0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Four responder instances share one clock and one reset: WAIT = 2, 0, 4
// and 15. Each instance has its own request and response signals. Latency
// here is the number of rising edges after the acceptance edge, up to and
// including the first edge that samples resp_valid = 1. That value is
// WAIT + 1.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_wen;
    logic [31:0] req_addr   [4];
    logic [31:0] req_wdata  [4];
    logic [3:0]  resp_valid;
    logic [31:0] resp_rdata [4];
    logic [3:0]  resp_err;

    int vectors;
    int miscompares;

    dmem_responder #(.ADDR_W(8), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.ADDR_W(8), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    dmem_responder #(.ADDR_W(8), .WAIT(4)) u_w4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    dmem_responder #(.ADDR_W(8), .WAIT(15)) u_w15 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[3]), .req_ready(req_ready[3]),
        .req_wen(req_wen[3]), .req_addr(req_addr[3]), .req_wdata(req_wdata[3]),
        .resp_valid(resp_valid[3]), .resp_rdata(resp_rdata[3]), .resp_err(resp_err[3])
    );

    // 10 ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request into instance d and waits for its response. It
    // returns the response fields and the latency, or lat = -1 on timeout.
    // ready_hi counts the busy cycles in which req_ready was wrongly 1.
    task automatic do_req(input int d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int ready_hi);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_wen[d]   = 1'b0;
        req_addr[d]  = 32'hFFFF_FFFF;
        req_wdata[d] = 32'hFFFF_FFFF;
        lat      = -1;
        ready_hi = 0;
        rdata    = 32'd0;
        err      = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (req_ready[d]) ready_hi++;
            if (resp_valid[d]) begin
                lat   = i;
                rdata = resp_rdata[d];
                err   = resp_err[d];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs dut%0d: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 4'b0000 || req_ready !== 4'b1111) begin
                miscompares++;
                $display("[TB] FAIL idle_hold cycle%0d: valid=%b ready=%b, want 0000 1111",
                         c, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rh;
        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, rh);
        vectors++;
        if (lat !== 3 || rd !== 32'd0 || er !== 1'b0 || rh !== 0) begin
            miscompares++;
            $display("[TB] FAIL store_w2: lat=%0d rdata=%h err=%b ready_hi=%0d, want 3 0 0 0",
                     lat, rd, er, rh);
        end
        @(negedge clk);
        vectors++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL store_pulse_end: valid=%b ready=%b, want 0 1",
                     resp_valid[0], req_ready[0]);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat, rh);
        vectors++;
        if (lat !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_w2: lat=%0d rdata=%h err=%b, want 3 deadbeef 0",
                     lat, rd, er);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rh;
        do_req(0, 1'b0, 32'h12, 32'h0, rd, er, lat, rh);
        vectors++;
        if (lat !== 3 || rd !== 32'd0 || er !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL misaligned_load: lat=%0d rdata=%h err=%b, want 3 0 1",
                     lat, rd, er);
        end
        do_req(0, 1'b1, 32'h0, 32'h1111_1111, rd, er, lat, rh);
        do_req(0, 1'b1, 32'h400, 32'h1, rd, er, lat, rh);
        vectors++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL oob_store: rdata=%h err=%b, want 0 1", rd, er);
        end
        do_req(0, 1'b0, 32'h0, 32'h0, rd, er, lat, rh);
        vectors++;
        if (rd !== 32'h1111_1111 || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL no_alias_load0: rdata=%h err=%b, want 11111111 0", rd, er);
        end
        do_req(0, 1'b1, 32'h3FC, 32'hCAFE_F00D, rd, er, lat, rh);
        do_req(0, 1'b0, 32'h3FC, 32'h0, rd, er, lat, rh);
        vectors++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL top_word_load: rdata=%h err=%b, want cafef00d 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rh;
        do_req(1, 1'b1, 32'h40, 32'hA5A5_0001, rd, er, lat, rh);
        vectors++;
        if (lat !== 1 || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL store_w0: lat=%0d err=%b, want 1 0", lat, er);
        end
        do_req(1, 1'b1, 32'h44, 32'h0000_B002, rd, er, lat, rh);
        // req_valid stays high across both loads. While the instance is busy,
        // the address switches to a misaligned value that must be ignored.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b0;
        req_addr[1]  = 32'h40;
        vectors++;
        if (req_ready[1] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready0: ready=%b, want 1", req_ready[1]);
        end
        @(negedge clk);
        vectors++;
        if (req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b1 ||
            resp_rdata[1] !== 32'hA5A5_0001 || resp_err[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_resp1: ready=%b valid=%b rdata=%h err=%b, want 0 1 a5a50001 0",
                     req_ready[1], resp_valid[1], resp_rdata[1], resp_err[1]);
        end
        req_addr[1] = 32'h12;
        @(negedge clk);
        vectors++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready2: ready=%b valid=%b, want 1 0",
                     req_ready[1], resp_valid[1]);
        end
        req_addr[1] = 32'h44;
        @(negedge clk);
        vectors++;
        if (req_ready[1] !== 1'b0 || resp_valid[1] !== 1'b1 ||
            resp_rdata[1] !== 32'h0000_B002 || resp_err[1] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_resp2: ready=%b valid=%b rdata=%h err=%b, want 0 1 0000b002 0",
                     req_ready[1], resp_valid[1], resp_rdata[1], resp_err[1]);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rh;
        int          seen;
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_wen[2]   = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        req_wen[2]   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready[2] !== 1'b1 || resp_valid[2] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_wait_reset: ready=%b valid=%b, want 1 0",
                     req_ready[2], resp_valid[2]);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid[2]) seen++;
        end
        vectors++;
        if (seen !== 0 || req_ready[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL dropped_resp: pulses=%0d ready=%b, want 0 1", seen, req_ready[2]);
        end
        do_req(2, 1'b0, 32'h20, 32'h0, rd, er, lat, rh);
        vectors++;
        if (lat !== 5 || rd !== 32'h5A5A_5A5A || er !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL committed_store: lat=%0d rdata=%h err=%b, want 5 5a5a5a5a 0",
                     lat, rd, er);
        end
    endtask

    task automatic test_max_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rh;
        do_req(3, 1'b1, 32'h8, 32'h0BAD_C0DE, rd, er, lat, rh);
        do_req(3, 1'b0, 32'h8, 32'h0, rd, er, lat, rh);
        vectors++;
        if (lat !== 16 || rd !== 32'h0BAD_C0DE || er !== 1'b0 || rh !== 0) begin
            miscompares++;
            $display("[TB] FAIL max_wait_load: lat=%0d rdata=%h err=%b ready_hi=%0d, want 16 0badc0de 0 0",
                     lat, rd, er, rh);
        end
        @(negedge clk);
        vectors++;
        if (resp_valid[3] !== 1'b0 || resp_rdata[3] !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL max_wait_single_pulse: valid=%b rdata=%h, want 0 0",
                     resp_valid[3], resp_rdata[3]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        req_valid   = 4'b0000;
        req_wen     = 4'b0000;
        for (int d = 0; d < 4; d++) begin
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
        end
        test_reset();
        test_store_load();
        test_faults();
        test_back_to_back();
        test_reset_mid_wait();
        test_max_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
